// File: rtl/jtcps1_vram_slotarb.sv
// jtcps1_vram_slotarb
// Four-slot read arbiter between the CPS1 video memory clients (tile-map VRAM,
// OBJ VRAM, palette VRAM, GFX ROM) and the single SDRAM read port. Each slot
// keeps a one-entry cache of its last fetched word; only a cache miss
// generates an SDRAM access, and only one access is outstanding at a time.
//
// Ports:
//   clk, rstn         clock (rising edge) and asynchronous active-low reset
//   slot_cs[3:0]      per-slot read request, held until slot_ok
//   slot_addr         per-slot word address, slot i at [i*AW +: AW]
//   slot_clr[3:0]     per-slot cache invalidate pulse
//   slot_dout         per-slot cached word, slot i at [i*32 +: 32]
//   slot_ok[3:0]      per-slot data valid for the current address (registered)
//   sdram_req/ack     SDRAM request and acceptance
//   sdram_addr        offset-adjusted request address
//   data_rdy/read     one-cycle read data strobe and data
//   refresh_en        controller may refresh (arbiter idle, nothing pending)
//   state_dbg         current arbiter state (IDLE=0, REQ=1, WAIT=2)
//
// Handshake: sdram_req rises with sdram_addr stable and stays high until the
// cycle in which sdram_ack is sampled high; data_rdy is a one-cycle strobe
// qualifying data_read and may coincide with sdram_ack. A data_rdy seen
// outside REQ/WAIT is ignored.
//
// Build option: define JTCPS1_ARB_FIXPRIO_EN for fixed priority (slot 0
// highest); otherwise pending slots are served round-robin.

module jtcps1_vram_slotarb #(
  parameter int          AW      = 22,
  parameter logic [AW-1:0] OFFSET0 = 22'h3B_0000,
  parameter logic [AW-1:0] OFFSET1 = 22'h3B_0000,
  parameter logic [AW-1:0] OFFSET2 = 22'h3B_0000,
  parameter logic [AW-1:0] OFFSET3 = 22'h0A_8000
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [3:0]      slot_cs,
  input  logic [4*AW-1:0] slot_addr,
  input  logic [3:0]      slot_clr,
  output logic [127:0]    slot_dout,
  output logic [3:0]      slot_ok,
  output logic            sdram_req,
  input  logic            sdram_ack,
  output logic [AW-1:0]   sdram_addr,
  input  logic            data_rdy,
  input  logic [31:0]     data_read,
  output logic            refresh_en,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t        state, state_nxt;

  logic [3:0]    valid;
  logic [AW-1:0] tag  [4];
  logic [31:0]   data [4];
  logic [1:0]    ptr;
  logic [1:0]    cur;
  logic          drop;       // clear seen for the slot in flight
  logic [AW-1:0] req_addr;   // un-offset address of the access in flight

  logic [AW-1:0] addr_a [4];
  logic [AW-1:0] off_a  [4];
  logic [3:0]    hit, pend;
  logic [1:0]    pick;
  logic          issue, fill;

  assign off_a[0] = OFFSET0;
  assign off_a[1] = OFFSET1;
  assign off_a[2] = OFFSET2;
  assign off_a[3] = OFFSET3;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      addr_a[i] = slot_addr[i*AW +: AW];
      hit[i]    = slot_cs[i] & valid[i] & (tag[i] == addr_a[i]);
      pend[i]   = slot_cs[i] & ~hit[i];
    end
  end

`ifdef JTCPS1_ARB_FIXPRIO_EN
  // Lowest index wins: scan downward so the last match is the smallest.
  always_comb begin
    pick = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pend[i]) pick = 2'(i);
    end
  end
`else
  logic       rr_found;
  logic [1:0] rr_idx;

  // First pending slot at or above the pointer, wrapping modulo 4.
  always_comb begin
    pick     = ptr;
    rr_found = 1'b0;
    rr_idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      rr_idx = ptr + 2'(k);
      if (!rr_found && pend[rr_idx]) begin
        pick     = rr_idx;
        rr_found = 1'b1;
      end
    end
  end
`endif

  // Next-state logic. fill marks the cycle in which returned data is stored;
  // an ack coinciding with data_rdy in REQ skips WAIT.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    fill      = 1'b0;
    case (state)
      IDLE: begin
        if (|pend) begin
          issue     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (sdram_ack) begin
          fill      = data_rdy;
          state_nxt = data_rdy ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (data_rdy) begin
          fill      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid      <= 4'd0;
      ptr        <= 2'd0;
      cur        <= 2'd0;
      drop       <= 1'b0;
      req_addr   <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      slot_ok    <= 4'd0;
      refresh_en <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        tag[i]  <= '0;
        data[i] <= 32'd0;
      end
    end else begin
      slot_ok    <= hit & ~slot_clr;
      refresh_en <= (state == IDLE) & ~|pend;
      valid      <= valid & ~slot_clr;

      if (issue) begin
        cur        <= pick;
        req_addr   <= addr_a[pick];
        sdram_addr <= addr_a[pick] + off_a[pick];
        sdram_req  <= 1'b1;
        // A clear in the issue cycle already refers to the word being fetched.
        drop       <= slot_clr[pick];
      end else if (state == REQ && sdram_ack) begin
        sdram_req  <= 1'b0;
      end

      if (state != IDLE && slot_clr[cur]) drop <= 1'b1;

      // Data is always stored; the clear (sticky or same-cycle) wins over valid.
      if (fill) begin
        data[cur]  <= data_read;
        tag[cur]   <= req_addr;
        valid[cur] <= ~(drop | slot_clr[cur]);
        ptr        <= cur + 2'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      slot_dout[i*32 +: 32] = data[i];
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_jtcps1_vram_slotarb.sv
// Testbench for jtcps1_vram_slotarb.
// Stimulus tasks push the expected SDRAM addresses into exp_q and the expected
// {slot, word} of each slot_ok rise into ok_q; a monitor on the falling clock
// edge pops and compares whenever sdram_req or a slot_ok bit rises. Timing-
// and reset-related values are checked inline by the stimulus thread.

module tb_jtcps1_vram_slotarb;

  localparam int AW = 22;

  logic            clk;
  logic            rstn;
  logic [3:0]      slot_cs;
  logic [4*AW-1:0] slot_addr;
  logic [3:0]      slot_clr;
  logic [127:0]    slot_dout;
  logic [3:0]      slot_ok;
  logic            sdram_req;
  logic            sdram_ack;
  logic [AW-1:0]   sdram_addr;
  logic            data_rdy;
  logic [31:0]     data_read;
  logic            refresh_en;
  logic [1:0]      state_dbg;

  jtcps1_vram_slotarb dut (
    .clk        (clk),
    .rstn       (rstn),
    .slot_cs    (slot_cs),
    .slot_addr  (slot_addr),
    .slot_clr   (slot_clr),
    .slot_dout  (slot_dout),
    .slot_ok    (slot_ok),
    .sdram_req  (sdram_req),
    .sdram_ack  (sdram_ack),
    .sdram_addr (sdram_addr),
    .data_rdy   (data_rdy),
    .data_read  (data_read),
    .refresh_en (refresh_en),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [AW-1:0] exp_q[$];
  logic [33:0]   ok_q[$];
  int            n_chk  = 0;
  int            n_fail = 0;

  logic          req_prev = 1'b0;
  logic [3:0]    ok_prev  = 4'd0;
  logic [AW-1:0] mon_e;
  logic [33:0]   mon_o;

  always @(negedge clk) begin
    if (rstn) begin
      if (sdram_req && !req_prev) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL req_unexpected: got sdram_addr=%h, none expected", sdram_addr);
        end else begin
          mon_e = exp_q.pop_front();
          if (sdram_addr !== mon_e) begin
            n_fail++;
            $display("FAIL req_addr: got %h expected %h", sdram_addr, mon_e);
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (slot_ok[i] && !ok_prev[i]) begin
          n_chk++;
          if (ok_q.size() == 0) begin
            n_fail++;
            $display("FAIL ok_unexpected: slot %0d rose, none expected", i);
          end else begin
            mon_o = ok_q.pop_front();
            if (mon_o !== {2'(i), slot_dout[i*32 +: 32]}) begin
              n_fail++;
              $display("FAIL ok_data: got slot %0d word %h expected slot %0d word %h",
                       i, slot_dout[i*32 +: 32], mon_o[33:32], mon_o[31:0]);
            end
          end
        end
      end
    end
    req_prev = sdram_req;
    ok_prev  = slot_ok;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_addr(input int slot, input logic [AW-1:0] a);
    slot_addr[slot*AW +: AW] = a;
  endtask

  task automatic expect_ok(input int slot, input logic [31:0] d);
    ok_q.push_back({2'(slot), d});
  endtask

  // Wait (bounded) for a request, then ack after ack_dly cycles.
  // Returns on the falling edge after the ack, with the arbiter in WAIT.
  task automatic grant(input int ack_dly);
    int n;
    n = 0;
    while (!sdram_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (!sdram_req) begin
      n_fail++;
      $display("FAIL grant_timeout: sdram_req=%b expected 1 within 50 cycles", sdram_req);
      return;
    end
    repeat (ack_dly) @(negedge clk);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
  endtask

  // Return a word after rdy_dly cycles; clr is driven together with data_rdy.
  // Returns one falling edge after the data_rdy strobe.
  task automatic reply(input int rdy_dly, input logic [31:0] d, input logic [3:0] clr);
    repeat (rdy_dly) @(negedge clk);
    data_rdy  = 1'b1;
    data_read = d;
    slot_clr  = clr;
    @(negedge clk);
    data_rdy  = 1'b0;
    slot_clr  = 4'd0;
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    slot_cs   = 4'd0;
    slot_clr  = 4'd0;
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick(1);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rr_d [8];

  initial begin
    rstn      = 1'b0;
    slot_cs   = 4'd0;
    slot_addr = '0;
    slot_clr  = 4'd0;
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    data_read = 32'd0;
    for (int i = 0; i < 8; i++) rr_d[i] = 32'hC0DE_0000 + 32'(i);

    // Reset values
    tick(1);
    check("rst_ok",      128'(slot_ok),    128'd0);
    check("rst_req",     128'(sdram_req),  128'd0);
    check("rst_addr",    128'(sdram_addr), 128'd0);
    check("rst_refresh", 128'(refresh_en), 128'd0);
    check("rst_dout",    slot_dout,        128'd0);
    check("rst_state",   128'(state_dbg),  128'd0);
    rstn = 1'b1;
    tick(2);
    check("idle_refresh", 128'(refresh_en), 128'd1);

    // Miss then hit
    exp_q.push_back(22'h3B_0010);
    expect_ok(0, 32'hDEAD_BEEF);
    set_addr(0, 22'h00010);
    slot_cs[0] = 1'b1;
    grant(1);
    reply(5, 32'hDEAD_BEEF, 4'd0);
    check("miss_ok_lat1", 128'(slot_ok[0]), 128'd0);
    tick(1);
    check("miss_ok_lat2", 128'(slot_ok[0]), 128'd1);
    slot_cs[0] = 1'b0;
    tick(1);
    check("cs_drop_ok", 128'(slot_ok[0]), 128'd0);
    expect_ok(0, 32'hDEAD_BEEF);
    slot_cs[0] = 1'b1;
    tick(1);
    check("hit_ok",      128'(slot_ok[0]), 128'd1);
    check("hit_no_req",  128'(sdram_req),  128'd0);
    check("hit_refresh", 128'(refresh_en), 128'd1);
    slot_cs = 4'd0;
    tick(2);

    // Round robin from pointer 0
    do_reset();
    set_addr(0, 22'h20); set_addr(1, 22'h30); set_addr(2, 22'h40); set_addr(3, 22'h50);
    exp_q.push_back(22'h3B_0020); exp_q.push_back(22'h3B_0030);
    exp_q.push_back(22'h3B_0040); exp_q.push_back(22'h0A_8050);
    for (int i = 0; i < 4; i++) expect_ok(i, rr_d[i]);
    slot_cs = 4'hF;
    for (int i = 0; i < 4; i++) begin
      grant(0);
      reply(1, rr_d[i], 4'd0);
    end
    tick(2);
    check("rr_all_hit", 128'(slot_ok), 128'hF);
    // Pointer back at 0: slots 1 and 2 re-requested
    exp_q.push_back(22'h3B_0034); exp_q.push_back(22'h3B_0044);
    expect_ok(1, rr_d[4]); expect_ok(2, rr_d[5]);
    set_addr(1, 22'h34); set_addr(2, 22'h44);
    grant(0); reply(1, rr_d[4], 4'd0);
    grant(0); reply(1, rr_d[5], 4'd0);
    tick(2);
    // Pointer now at 3: slots 0 and 3 re-requested
`ifdef JTCPS1_ARB_FIXPRIO_EN
    exp_q.push_back(22'h3B_0024); exp_q.push_back(22'h0A_8054);
    expect_ok(0, rr_d[6]); expect_ok(3, rr_d[7]);
`else
    exp_q.push_back(22'h0A_8054); exp_q.push_back(22'h3B_0024);
    expect_ok(3, rr_d[6]); expect_ok(0, rr_d[7]);
`endif
    set_addr(0, 22'h24); set_addr(3, 22'h54);
    grant(0); reply(1, rr_d[6], 4'd0);
    grant(0); reply(1, rr_d[7], 4'd0);
    tick(2);
    check("rr_all_hit2", 128'(slot_ok), 128'hF);
    slot_cs = 4'd0;
    tick(2);

    // Offset wrap
    exp_q.push_back(22'h0A_7FFF);
    expect_ok(3, 32'hCAFE_0003);
    set_addr(3, 22'h3F_FFFF);
    slot_cs[3] = 1'b1;
    grant(0);
    reply(2, 32'hCAFE_0003, 4'd0);
    tick(1);
    check("wrap_ok", 128'(slot_ok[3]), 128'd1);
    slot_cs = 4'd0;
    tick(2);

    // Clear during WAIT
    exp_q.push_back(22'h3B_0060); exp_q.push_back(22'h3B_0060);
    set_addr(1, 22'h60);
    slot_cs[1] = 1'b1;
    grant(0);
    slot_clr = 4'b0010;
    tick(1);
    slot_clr = 4'd0;
    reply(1, 32'h1111_2222, 4'd0);
    check("clr_dout", 128'(slot_dout[63:32]), 128'h1111_2222);
    check("clr_ok1",  128'(slot_ok[1]), 128'd0);
    tick(1);
    check("clr_rereq", 128'(sdram_req), 128'd1);
    check("clr_ok2",   128'(slot_ok[1]), 128'd0);
    expect_ok(1, 32'h3333_4444);
    grant(0);
    reply(1, 32'h3333_4444, 4'd0);
    tick(1);
    check("clr_ok_final", 128'(slot_ok[1]), 128'd1);

    // Clear together with data_rdy
    exp_q.push_back(22'h3B_0068); exp_q.push_back(22'h3B_0068);
    set_addr(1, 22'h68);
    grant(0);
    reply(1, 32'h5555_6666, 4'b0010);
    check("clrrdy_dout", 128'(slot_dout[63:32]), 128'h5555_6666);
    check("clrrdy_ok1",  128'(slot_ok[1]), 128'd0);
    tick(1);
    check("clrrdy_rereq", 128'(sdram_req), 128'd1);
    check("clrrdy_ok2",   128'(slot_ok[1]), 128'd0);
    expect_ok(1, 32'h7777_8888);
    grant(0);
    reply(1, 32'h7777_8888, 4'd0);
    tick(1);
    check("clrrdy_ok_final", 128'(slot_ok[1]), 128'd1);
    slot_cs = 4'd0;
    tick(2);

    // Address change during WAIT
    exp_q.push_back(22'h3B_0100); exp_q.push_back(22'h3B_0104);
    set_addr(2, 22'h100);
    slot_cs[2] = 1'b1;
    grant(0);
    set_addr(2, 22'h104);
    reply(1, 32'hAAAA_0100, 4'd0);
    check("chg_dout", 128'(slot_dout[95:64]), 128'hAAAA_0100);
    check("chg_ok1",  128'(slot_ok[2]), 128'd0);
    tick(1);
    check("chg_ok2",   128'(slot_ok[2]), 128'd0);
    check("chg_rereq", 128'(sdram_req), 128'd1);
    expect_ok(2, 32'hAAAA_0104);
    grant(0);
    reply(1, 32'hAAAA_0104, 4'd0);
    tick(1);
    check("chg_ok_final", 128'(slot_ok[2]), 128'd1);
    slot_cs = 4'd0;
    tick(2);

    // Asynchronous reset in WAIT
    expect_ok(3, 32'hCAFE_0003);
    exp_q.push_back(22'h3B_0200);
    set_addr(3, 22'h3F_FFFF);
    set_addr(0, 22'h200);
    slot_cs = 4'b1001;
    grant(0);
    check("pre_rst_ok",    128'(slot_ok),   128'b1000);
    check("pre_rst_state", 128'(state_dbg), 128'd2);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_req",     128'(sdram_req),  128'd0);
    check("arst_ok",      128'(slot_ok),    128'd0);
    check("arst_addr",    128'(sdram_addr), 128'd0);
    check("arst_state",   128'(state_dbg),  128'd0);
    check("arst_refresh", 128'(refresh_en), 128'd0);
    slot_cs = 4'd0;
    tick(1);
    rstn = 1'b1;
    tick(1);
    data_rdy  = 1'b1;
    data_read = 32'h0BAD_0BAD;
    tick(1);
    data_rdy = 1'b0;
    check("stray_refresh", 128'(refresh_en), 128'd1);
    check("stray_dout",    slot_dout,        128'd0);
    exp_q.push_back(22'h3B_0200);
    set_addr(0, 22'h200);
    slot_cs[0] = 1'b1;
    tick(1);
    check("stray_no_hit", 128'(slot_ok[0]), 128'd0);
    expect_ok(0, 32'h1234_5678);
    grant(0);
    reply(1, 32'h1234_5678, 4'd0);
    tick(1);
    check("post_rst_ok", 128'(slot_ok[0]), 128'd1);
    slot_cs = 4'd0;
    tick(3);

    check("exp_q_empty", 128'(exp_q.size()), 128'd0);
    check("ok_q_empty",  128'(ok_q.size()),  128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
